// File: rtl/mcycle_controller.sv
// mcycle_controller: main control FSM for the multicycle ARM core.
// One state machine sequences fetch, decode, memory, ALU, branch and a
// parametrised multiply, with integrated condition logic and flag register.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   Instr        instruction register contents
//   ALUFlags     {N,Z,C,V} from the ALU, sampled at the end of EXECR/EXECI
//   MemReady     memory handshake, 1 = access completes this cycle
//   PCWrite, MemWrite, RegWrite, IRWrite   datapath write enables
//   AdrSrc, ALUSrcA, ALUSrcB, RegSrc, ImmSrc, ResultSrc, ALUControl  selects
//   MulStart     one-cycle start pulse to the multiplier
//   Busy         high in every state except FETCH
module mcycle_controller #(
    parameter int unsigned MUL_CYCLES = 4,
    parameter bit          EN_MUL     = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instr,
    input  logic [3:0]  ALUFlags,
    input  logic        MemReady,
    output logic        PCWrite,
    output logic        MemWrite,
    output logic        RegWrite,
    output logic        IRWrite,
    output logic        AdrSrc,
    output logic        ALUSrcA,
    output logic [1:0]  RegSrc,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ImmSrc,
    output logic [1:0]  ResultSrc,
    output logic [2:0]  ALUControl,
    output logic        MulStart,
    output logic        Busy
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MUL_CYCLES - 1);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_MULEX  = 4'd10
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       flags_q, flags_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [1:0] op;
    logic [3:0] cmd;
    logic [3:0] cond;
    logic [3:0] rd;
    logic       mul_pat, is_mul;
    logic [2:0] alu_ctl;
    logic       cmd_ok, is_cmp, is_arith;
    logic       cond_ex;
    logic       unused_instr_bits;

    // Instruction field decode
    assign op       = Instr[27:26];
    assign cmd      = Instr[24:21];
    assign cond     = Instr[31:28];
    assign mul_pat  = (op == 2'b00) && (Instr[25:22] == 4'b0000) && (Instr[7:4] == 4'b1001);
    assign is_mul   = EN_MUL && mul_pat;
    // MUL places its destination in [19:16]; data-processing in [15:12]
    assign rd       = is_mul ? Instr[19:16] : Instr[15:12];
    assign RegSrc   = {op == 2'b01, op == 2'b10};
    assign ImmSrc   = op;
    assign Busy     = (state_q != S_FETCH);
    assign unused_instr_bits = ^{Instr[11:8], Instr[3:0]};

    // ALU operation decode; CMP reuses SUB
    always_comb begin
        alu_ctl  = 3'b000;
        cmd_ok   = 1'b1;
        is_cmp   = 1'b0;
        is_arith = 1'b0;
        case (cmd)
            4'b0100: begin alu_ctl = 3'b000; is_arith = 1'b1; end
            4'b0010: begin alu_ctl = 3'b001; is_arith = 1'b1; end
            4'b0000: alu_ctl = 3'b010;
            4'b1100: alu_ctl = 3'b011;
            4'b0001: alu_ctl = 3'b100;
            4'b1010: begin alu_ctl = 3'b001; is_arith = 1'b1; is_cmp = 1'b1; end
            default: cmd_ok = 1'b0;
        endcase
    end

    // ARM condition evaluation against the stored flags {N,Z,C,V}
    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            4'b0000: cond_ex = flags_q[2];
            4'b0001: cond_ex = !flags_q[2];
            4'b0010: cond_ex = flags_q[1];
            4'b0011: cond_ex = !flags_q[1];
            4'b0100: cond_ex = flags_q[3];
            4'b0101: cond_ex = !flags_q[3];
            4'b0110: cond_ex = flags_q[0];
            4'b0111: cond_ex = !flags_q[0];
            4'b1000: cond_ex = flags_q[1] && !flags_q[2];
            4'b1001: cond_ex = !flags_q[1] || flags_q[2];
            4'b1010: cond_ex = (flags_q[3] == flags_q[0]);
            4'b1011: cond_ex = (flags_q[3] != flags_q[0]);
            4'b1100: cond_ex = !flags_q[2] && (flags_q[3] == flags_q[0]);
            4'b1101: cond_ex = flags_q[2] || (flags_q[3] != flags_q[0]);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    // State, flag and multiply-counter registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
            flags_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            flags_q <= flags_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and output decode
    always_comb begin
        state_d    = state_q;
        flags_d    = flags_q;
        cnt_d      = cnt_q;
        PCWrite    = 1'b0;
        MemWrite   = 1'b0;
        RegWrite   = 1'b0;
        IRWrite    = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        ALUControl = 3'b000;
        MulStart   = 1'b0;
        case (state_q)
            S_FETCH: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = MemReady;
                PCWrite   = MemReady;
                if (MemReady) state_d = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                case (op)
                    2'b01: state_d = S_MEMADR;
                    2'b10: state_d = S_BRANCH;
                    2'b00: begin
                        if (Instr[25])     state_d = S_EXECI;
                        else if (is_mul) begin
                            state_d = S_MULEX;
                            cnt_d   = CNT_INIT;
                        end
                        else if (mul_pat)  state_d = S_FETCH;
                        else               state_d = S_EXECR;
                    end
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                ALUSrcB = 2'b01;
                state_d = Instr[20] ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                AdrSrc = 1'b1;
                if (MemReady) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = cond_ex;
                state_d   = S_FETCH;
            end
            S_MEMWR: begin
                AdrSrc   = 1'b1;
                MemWrite = cond_ex;
                if (MemReady) state_d = S_FETCH;
            end
            S_EXECR, S_EXECI: begin
                ALUSrcB    = (state_q == S_EXECI) ? 2'b01 : 2'b00;
                ALUControl = alu_ctl;
                state_d    = (cmd_ok && !is_cmp) ? S_ALUWB : S_FETCH;
                if (cmd_ok && (Instr[20] || is_cmp) && cond_ex) begin
                    flags_d[3:2] = ALUFlags[3:2];
                    if (is_arith) flags_d[1:0] = ALUFlags[1:0];
                end
            end
            S_ALUWB: begin
                ResultSrc = is_mul ? 2'b11 : 2'b00;
                if (rd == 4'd15) PCWrite  = cond_ex;
                else             RegWrite = cond_ex;
                state_d = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                PCWrite   = cond_ex;
                state_d   = S_FETCH;
            end
            S_MULEX: begin
                MulStart = (cnt_q == CNT_INIT);
                if (cnt_q == '0) state_d = S_ALUWB;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            default: state_d = S_FETCH;
        endcase
        // No write enable or start pulse may escape while reset is held
        if (!reset) begin
            PCWrite  = 1'b0;
            MemWrite = 1'b0;
            RegWrite = 1'b0;
            IRWrite  = 1'b0;
            MulStart = 1'b0;
        end
    end

endmodule

// File: tb/tb_mcycle_controller.sv
// Bench for mcycle_controller: directed program plus random instructions,
// each checked cycle by cycle against an instruction-level reference model.
module tb_mcycle_controller;

    localparam int unsigned MULC = 4;

    logic        clk, reset;
    logic [31:0] Instr;
    logic [3:0]  ALUFlags;
    logic        MemReady;
    logic        PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA;
    logic [1:0]  RegSrc, ALUSrcB, ImmSrc, ResultSrc;
    logic [2:0]  ALUControl;
    logic        MulStart, Busy;

    mcycle_controller #(.MUL_CYCLES(MULC), .EN_MUL(1'b1)) dut (
        .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
        .MemReady(MemReady), .PCWrite(PCWrite), .MemWrite(MemWrite),
        .RegWrite(RegWrite), .IRWrite(IRWrite), .AdrSrc(AdrSrc),
        .ALUSrcA(ALUSrcA), .RegSrc(RegSrc), .ALUSrcB(ALUSrcB),
        .ImmSrc(ImmSrc), .ResultSrc(ResultSrc), .ALUControl(ALUControl),
        .MulStart(MulStart), .Busy(Busy)
    );

    typedef struct packed {
        logic       busy, pcw, regw, memw, irw, mst, adr, asa;
        logic [1:0] asb, rs;
        logic [2:0] alu;
    } exp_t;

    typedef struct packed {
        logic mr;
        exp_t e;
    } cyc_t;

    cyc_t       tr[$];
    int         total = 0;
    int         bad   = 0;
    logic [3:0] m_flags = 4'b0000;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v;
        {n, z, cf, v} = f;
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cf;
            4'd3:  return !cf;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return cf && !z;
            4'd9:  return !cf || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic exp_t observe();
        exp_t o;
        o.busy = Busy;     o.pcw = PCWrite;   o.regw = RegWrite; o.memw = MemWrite;
        o.irw  = IRWrite;  o.mst = MulStart;  o.adr  = AdrSrc;   o.asa  = ALUSrcA;
        o.asb  = ALUSrcB;  o.rs  = ResultSrc; o.alu  = ALUControl;
        return o;
    endfunction

    function automatic logic rmr();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic void add(input logic mr, input exp_t e);
        cyc_t c;
        c.mr = mr;
        c.e  = e;
        tr.push_back(c);
    endfunction

    function automatic exp_t fetch_exp();
        exp_t e;
        e = '0;
        e.asa = 1'b1; e.asb = 2'b10; e.rs = 2'b10;
        return e;
    endfunction

    task automatic check(input exp_t want, input string tag, input int idx);
        exp_t got;
        got = observe();
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s[%0d]: observed=%h expected=%h", tag, idx, got, want);
        end
    endtask

    // Entered and left just after a falling edge
    task automatic do_reset(input int n);
        reset    = 1'b0;
        MemReady = 1'b1;
        for (int k = 0; k < n; k++) begin
            #1;
            check(fetch_exp(), "reset", k);
            @(negedge clk);
        end
        reset   = 1'b1;
        m_flags = 4'b0000;
    endtask

    // Build the expected per-cycle trace of one instruction, then play it.
    // fw: FETCH wait cycles, mw: MEMRD/MEMWR wait cycles, lim: cycles to run.
    task automatic run_instr(input logic [31:0] ins, input logic [3:0] af,
                             input int fw, input int mw, input int lim,
                             input string tag);
        exp_t       b, e;
        logic [3:0] nf;
        logic       ce, ce2, ok, cmp, arith;
        logic [2:0] alu;
        logic [1:0] op;
        logic [3:0] cmd;
        tr.delete();
        nf  = m_flags;
        ce  = cond_ok(ins[31:28], m_flags);
        op  = ins[27:26];
        cmd = ins[24:21];
        for (int k = 0; k < fw; k++) add(1'b0, fetch_exp());
        e = fetch_exp(); e.irw = 1'b1; e.pcw = 1'b1; add(1'b1, e);
        b = '0; b.busy = 1'b1;
        e = b; e.asa = 1'b1; e.asb = 2'b10; e.rs = 2'b10; add(rmr(), e);
        if (op == 2'b01) begin
            e = b; e.asb = 2'b01; add(rmr(), e);
            if (ins[20]) begin
                for (int k = 0; k <= mw; k++) begin
                    e = b; e.adr = 1'b1; add(k == mw, e);
                end
                e = b; e.rs = 2'b01; e.regw = ce; add(rmr(), e);
            end else begin
                for (int k = 0; k <= mw; k++) begin
                    e = b; e.adr = 1'b1; e.memw = ce; add(k == mw, e);
                end
            end
        end else if (op == 2'b10) begin
            e = b; e.asb = 2'b01; e.rs = 2'b10; e.pcw = ce; add(rmr(), e);
        end else if (op == 2'b00 && ins[25:22] == 4'b0000 && ins[7:4] == 4'b1001) begin
            for (int k = 0; k < int'(MULC); k++) begin
                e = b; e.mst = (k == 0); add(rmr(), e);
            end
            e = b; e.rs = 2'b11;
            if (ins[19:16] == 4'd15) e.pcw = ce; else e.regw = ce;
            add(rmr(), e);
        end else if (op == 2'b00) begin
            ok = 1'b1; cmp = 1'b0; arith = 1'b0; alu = 3'b000;
            case (cmd)
                4'b0100: begin alu = 3'b000; arith = 1'b1; end
                4'b0010: begin alu = 3'b001; arith = 1'b1; end
                4'b0000: alu = 3'b010;
                4'b1100: alu = 3'b011;
                4'b0001: alu = 3'b100;
                4'b1010: begin alu = 3'b001; arith = 1'b1; cmp = 1'b1; end
                default: ok = 1'b0;
            endcase
            e = b; e.asb = ins[25] ? 2'b01 : 2'b00; e.alu = alu; add(rmr(), e);
            if (ok && (ins[20] || cmp) && ce) begin
                nf[3:2] = af[3:2];
                if (arith) nf[1:0] = af[1:0];
            end
            if (ok && !cmp) begin
                ce2 = cond_ok(ins[31:28], nf);
                e = b;
                if (ins[15:12] == 4'd15) e.pcw = ce2; else e.regw = ce2;
                add(rmr(), e);
            end
        end
        for (int i = 0; i < int'(tr.size()) && i < lim; i++) begin
            if (i == 0) begin
                Instr    = ins;
                ALUFlags = af;
            end
            MemReady = tr[i].mr;
            #1;
            check(tr[i].e, tag, i);
            @(negedge clk);
        end
        if (lim >= int'(tr.size())) m_flags = nf;
    endtask

    localparam int FULL = 1000;

    initial begin
        logic [31:0] r;
        logic [3:0]  cmds [6];
        int          kind;
        cmds = '{4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b0001, 4'b1010};
        reset    = 1'b0;
        Instr    = '0;
        ALUFlags = '0;
        MemReady = 1'b1;
        @(negedge clk);
        do_reset(3);

        run_instr(32'hE0912003, 4'b0100, 2, 0, FULL, "adds_wait");
        run_instr(32'h00812003, 4'b1011, 0, 0, FULL, "addeq_after_z");
        run_instr(32'hE1510002, 4'b0100, 0, 0, FULL, "cmp_z");
        run_instr(32'h10812003, 4'b0000, 0, 0, FULL, "addne_skip");
        run_instr(32'hE5812000, 4'b0000, 0, 3, FULL, "str_wait");
        run_instr(32'hE5912000, 4'b0000, 1, 1, FULL, "ldr_wait");
        run_instr(32'hE0020391, 4'b1011, 0, 0, FULL, "mul");
        run_instr(32'h00812003, 4'b0000, 0, 0, FULL, "addeq_after_mul");
        run_instr(32'hEA000000, 4'b0000, 0, 0, FULL, "branch_al");
        run_instr(32'hE081F003, 4'b0000, 0, 0, FULL, "add_pc");
        run_instr(32'hF0812003, 4'b0000, 0, 0, FULL, "cond_nv");
        run_instr(32'hE3A00001, 4'b0000, 0, 0, FULL, "undef_cmd");
        run_instr(32'hE1510002, 4'b0100, 0, 0, FULL, "cmp_z2");
        run_instr(32'hE0812003, 4'b0000, 0, 0, 2,    "abort_add");
        do_reset(1);
        run_instr(32'h00812003, 4'b0100, 0, 0, FULL, "addeq_after_abort");
        run_instr(32'h10812003, 4'b0100, 0, 0, FULL, "addne_after_abort");

        for (int n = 0; n < 400; n++) begin
            r    = $urandom;
            kind = $urandom_range(0, 5);
            case (kind)
                0: r[27:26] = 2'b01;
                1: r[27:26] = 2'b10;
                2: r[27:26] = 2'b11;
                3: begin r[27:22] = 6'b000000; r[7:4] = 4'b1001; end
                default: begin
                    r[27:26] = 2'b00;
                    if ($urandom_range(0, 3) != 0) r[24:21] = cmds[$urandom_range(0, 5)];
                end
            endcase
            if ($urandom_range(0, 2) == 0) r[31:28] = 4'd14;
            if ($urandom_range(0, 3) == 0) r[15:12] = 4'd15;
            if ($urandom_range(0, 3) == 0) r[19:16] = 4'd15;
            run_instr(r, 4'($urandom), $urandom_range(0, 2), $urandom_range(0, 3), FULL, "rand");
            if (n % 97 == 50) do_reset(2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
